// File: rtl/power_sched_pkg.sv
// Shared widths and helpers for the power window scheduler.
// The squarer LUT maps a 5-bit sample to a 7-bit square.
package power_sched_pkg;

  localparam int SAMP_W = 5;
  localparam int SQ_W   = 7;

  function automatic int sum_w(input int win_log2);
    return SQ_W + win_log2;
  endfunction

endpackage

// File: rtl/power_window_scheduler_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr.
// Purely combinational; gnt is one-hot or zero.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW:0] NW = (IW+1)'(N);

  logic [IW:0] k;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr} + (IW+1)'(i);
      if (k >= NW)
        k = k - NW;
      if (en && !found && req[k[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = k[IW-1:0];
      end
    end
    if (found)
      gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/power_window_scheduler.sv
// Shares one squarer LUT across NCH channels and sums squares per window.
// Optional POWER_SCHED_THRESH_EN adds thr_i and a registered sum_over_o flag.
module power_window_scheduler
  import power_sched_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int WIN_LOG2 = 4,
  localparam int CW       = $clog2(NCH),
  localparam int SW       = sum_w(WIN_LOG2)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH*SAMP_W-1:0] samp_i,
  output logic [NCH-1:0]        ack_o,
  input  logic                  clear_i,
  output logic [SAMP_W-1:0]     sq_addr_o,
  input  logic [SQ_W-1:0]       sq_data_i,
  output logic [SW-1:0]         sum_o,
  output logic [CW-1:0]         sum_ch_o,
  output logic                  sum_valid_o,
  input  logic                  sum_ready_i
`ifdef POWER_SCHED_THRESH_EN
  ,
  input  logic [SW-1:0]         thr_i,
  output logic                  sum_over_o
`endif
);

  logic              adv;
  logic              en;
  logic              take;
  logic [NCH-1:0]    gnt;
  logic [CW-1:0]     gnt_idx;
  logic [CW-1:0]     rr;
  logic [CW-1:0]     s1_ch;
  logic              s1_v;
  logic [SAMP_W-1:0] samp [NCH];
  logic [SW-1:0]     acc  [NCH];
  logic [WIN_LOG2-1:0] cnt [NCH];
  logic [SW-1:0]     acc_nx;
  logic              win_done;

  // A held result stalls the whole pipe, so nothing is ever dropped.
  assign adv   = !(sum_valid_o && !sum_ready_i);
  assign en    = adv && !clear_i && rst_n_i;
  assign ack_o = gnt;
  assign take  = |gnt;

  for (genvar g = 0; g < NCH; g++) begin : g_samp
    assign samp[g] = samp_i[g*SAMP_W +: SAMP_W];
  end

  rr_arbiter #(
    .N(NCH)
  ) u_arb (
    .req     (req_i),
    .ptr     (rr),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr        <= '0;
      s1_v      <= 1'b0;
      s1_ch     <= '0;
      sq_addr_o <= '0;
    end else if (clear_i) begin
      rr   <= '0;
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v <= take;
      if (take) begin
        sq_addr_o <= samp[gnt_idx];
        s1_ch     <= gnt_idx;
        rr        <= (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + CW'(1);
      end
    end
  end

  assign acc_nx   = acc[s1_ch] + SW'(sq_data_i);
  assign win_done = s1_v && (cnt[s1_ch] == '1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (adv && s1_v) begin
      if (win_done) begin
        acc[s1_ch] <= '0;
        cnt[s1_ch] <= '0;
      end else begin
        acc[s1_ch] <= acc_nx;
        cnt[s1_ch] <= cnt[s1_ch] + (WIN_LOG2)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_o       <= '0;
      sum_ch_o    <= '0;
      sum_valid_o <= 1'b0;
`ifdef POWER_SCHED_THRESH_EN
      sum_over_o  <= 1'b0;
`endif
    end else if (clear_i) begin
      sum_valid_o <= 1'b0;
`ifdef POWER_SCHED_THRESH_EN
      sum_over_o  <= 1'b0;
`endif
    end else if (adv) begin
      if (win_done) begin
        sum_o       <= acc_nx;
        sum_ch_o    <= s1_ch;
        sum_valid_o <= 1'b1;
`ifdef POWER_SCHED_THRESH_EN
        sum_over_o  <= acc_nx > thr_i;
`endif
      end else if (sum_ready_i) begin
        sum_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/power_window_scheduler.md
# power_window_scheduler

Time-multiplexes one 5-bit→7-bit squarer LUT across `NCH` sample requesters, using round-robin arbitration. Each channel's squared samples are accumulated over a fixed window of `2**WIN_LOG2` accepted samples. When a window completes, the block emits a per-channel power sum on a valid/ready output. It sits between the per-channel sample formatters and the trigger/threshold logic in the GLITC power-detection path. The squarer is instantiated by the parent and driven from this block.

## Interface
Parameters:
- `NCH`, default 4: number of requesting channels (2–8).
- `WIN_LOG2`, default 4: window length is `2**WIN_LOG2` accepted samples per channel.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `req_i` in `NCH`: per-channel sample-valid request.
- `samp_i` in `NCH*5`: channel k sample is `samp_i[5k+4:5k]`.
- `ack_o` out `NCH`: one-hot grant. The sample is consumed on any cycle where `req_i[k] & ack_o[k]`.
- `clear_i` in 1: synchronous flush of all accumulators, counters and pipeline.
- `sq_addr_o` out 5: registered address to the external squarer LUT.
- `sq_data_i` in 7: combinational squarer result for `sq_addr_o`.
- `sum_o` out `7+WIN_LOG2`: completed window sum.
- `sum_ch_o` out `$clog2(NCH)`: channel index of `sum_o`.
- `sum_valid_o` out 1: output register holds a result.
- `sum_ready_i` in 1: consumer accepts the result on `sum_valid_o & sum_ready_i`.

## Operation
- **Advance.** `adv = !(sum_valid_o & !sum_ready_i)`. When `adv` is 0, the whole pipeline freezes:
  - no grant is issued;
  - stage registers hold;
  - accumulators hold.
- **Arbiter.** Round-robin pointer `rr`, reset 0. Each `adv` cycle:
  - grant the first asserted `req_i` at or after `rr` (wrapping);
  - on a grant, `rr` becomes the granted index + 1, wrapping at `NCH`;
  - with no requests, no grant and `rr` holds;
  - `ack_o` is combinational from `req_i`, `rr`, `adv` and `clear_i`, and is at most one-hot.
- **Stage 1** (registered):
  - `sq_addr_o` is loaded with the granted sample;
  - `s1_ch` is loaded with the granted index;
  - `s1_v` is set to grant-taken.
- **Stage 2** (registered, when `s1_v`):
  - `acc[s1_ch] += sq_data_i`;
  - `cnt[s1_ch] += 1`.
- **Window completion.** When `cnt[s1_ch] == 2**WIN_LOG2-1`:
  - `sum_o` is loaded with `acc[s1_ch] + sq_data_i`;
  - `sum_ch_o` is loaded with `s1_ch`;
  - `sum_valid_o` is set to 1;
  - `acc[s1_ch]` and `cnt[s1_ch]` are zeroed.
- **Output clear.** `sum_valid_o` clears on a handshake unless a new completion lands in the same cycle. Back-to-back results are allowed.
- **Width.** The sum width is exactly `7+WIN_LOG2`. The maximum, 127·2^WIN_LOG2, always fits, so there is no saturation and no wrap.
- **`clear_i`.** Has priority over everything:
  - `ack_o` is 0;
  - `s1_v` is 0 and the in-flight sample is discarded;
  - all `acc` and `cnt` are 0;
  - `sum_valid_o` is 0;
  - `rr` is 0.
- **Reset.** All outputs reset to 0: `ack_o`, `sq_addr_o`, `sum_o`, `sum_ch_o`, `sum_valid_o`. Internal `rr`, `s1_v`, `acc` and `cnt` also reset to 0. An assertion of `rst_n_i` in mid-window discards partial sums.

## Timing
- Sample accepted in cycle N.
- `sq_addr_o` valid in N+1.
- Accumulated at the end of N+1.
- For the window's last sample, `sum_valid_o` rises in N+2.
- Throughput is one sample per cycle aggregate, shared across channels.
- Freeze takes effect the same cycle `sum_valid_o & !sum_ready_i` is seen. It resumes the cycle after the handshake.

## Configuration
- **`POWER_SCHED_THRESH_EN` defined:**
  - adds input `thr_i` (`7+WIN_LOG2`);
  - adds output `sum_over_o` (1 bit), registered together with `sum_o`;
  - `sum_over_o` is 1 when the completed sum is strictly greater than `thr_i` sampled in the completion cycle;
  - `sum_over_o` resets and clears to 0.
- **Undefined:** neither port exists and no comparator is built.

## Structure
- Package `power_sched_pkg`:
  - `SAMP_W=5`;
  - `SQ_W=7`;
  - function `sum_w(win_log2)` returning `SQ_W+win_log2`.
- Sub-module `rr_arbiter`: parameter `N`; inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `gnt_idx`.
- Accumulator and counter arrays stay in the top level.

## Test plan
- **Reset:** assert `rst_n_i` low mid-stream. All outputs are 0 immediately. After release, the first grant goes to channel 0 if requesting.
- **Single channel:** ch0 requests continuously with sample 10 (LUT value 127), `WIN_LOG2`=4. There are 16 acks, `sum_o`=2032, `sum_ch_o`=0, and `sum_valid_o` rises 2 cycles after the 16th ack.
- **Four channels:** all request continuously; ch1 sample 0 (LUT 2), others sample 30 (LUT 0). Acks rotate 0,1,2,3. The ch1 sum is 32, the others 0, with results in channel order every cycle after 64 accepts.
- **Backpressure:** hold `sum_ready_i`=0 with `sum_valid_o`=1 for 10 cycles. `ack_o` stays 0, and `sum_o` and `sq_addr_o` are stable. After release, the next window completes with no sample lost or double-counted.
- **Clear mid-window:** ch0 sample 10, `clear_i` pulse after 5 acks. The next `sum_o` is 2032, produced only after 16 post-clear acks. The in-flight sample is not counted.
- **Threshold (`POWER_SCHED_THRESH_EN`):** `thr_i`=1000. A channel with sample 10 gives `sum_over_o`=1. A channel with sample 0 (sum 32) gives `sum_over_o`=0. With `thr_i`=2032 and sum 2032, `sum_over_o`=0.
